sme_port_arbiter: RTL

Two-client round-robin arbiter and sequencer that owns the single character-stream port of the string matching engine (SME). It grants one client at a time and forwards that client's string/pattern character stream to the SME with one registered stage. The SME result is routed back to the granted client. It also tracks which client loaded the SME's current string, and enforces stream-length limits and a result watchdog.

---
 rtl/sme_port_arbiter.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/sme_port_arbiter.sv
// Two-client round-robin owner of the SME character port: forwards the granted client's
// stream through one register stage, enforces burst limits and a result watchdog.
module sme_port_arbiter #(
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       c0_req,
    input  logic       c1_req,
    output logic       c0_gnt,
    output logic       c1_gnt,
    input  logic [7:0] c0_chardata,
    input  logic [7:0] c1_chardata,
    input  logic       c0_isstring,
    input  logic       c0_ispattern,
    input  logic       c1_isstring,
    input  logic       c1_ispattern,
    output logic       c0_valid,
    output logic       c0_match,
    output logic [4:0] c0_match_index,
    output logic       c0_stale,
    output logic       c0_trunc,
    output logic       c0_timeout,
    output logic       c1_valid,
    output logic       c1_match,
    output logic [4:0] c1_match_index,
    output logic       c1_stale,
    output logic       c1_trunc,
    output logic       c1_timeout,
    output logic [7:0] sme_chardata,
    output logic       sme_isstring,
    output logic       sme_ispattern,
    input  logic       sme_valid,
    input  logic       sme_match,
    input  logic [4:0] sme_match_index
);

    localparam int LIM_MAX = (STR_MAX > PAT_MAX) ? STR_MAX : PAT_MAX;
    localparam int CNT_W   = $clog2(LIM_MAX + 1);
    localparam int WD_W    = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GRANTED  = 3'd1,
        STRING   = 3'd2,
        PATTERN  = 3'd3,
        WAIT_RES = 3'd4
    } state_t;

    state_t           r_state;
    logic             r_sel;
    logic             r_last;
    logic             r_owner;
    logic             r_owner_vld;
    logic [CNT_W-1:0] r_cnt;
    logic [WD_W-1:0]  r_wd;
    logic             r_stale;
    logic             r_trunc;
    logic             r_gnt0;
    logic             r_gnt1;
    logic [7:0]       r_sme_char;
    logic             r_sme_str;
    logic             r_sme_pat;
    logic             r_vld0;
    logic             r_match0;
    logic [4:0]       r_idx0;
    logic             r_stale0;
    logic             r_trunc0;
    logic             r_to0;
    logic             r_vld1;
    logic             r_match1;
    logic [4:0]       r_idx1;
    logic             r_stale1;
    logic             r_trunc1;
    logic             r_to1;

    logic             w_req;
    logic             w_str;
    logic             w_pat;
    logic [7:0]       w_char;
    logic             w_pick1;
    logic             w_str_room;
    logic             w_pat_room;
    logic             w_stale_now;
    logic             w_wd_done;
    logic             w_res_fire;
    logic             w_res_match;
    logic [4:0]       w_res_idx;
    logic             w_res_to;

    // Only the granted client's inputs are ever looked at.
    assign w_req  = r_sel ? c1_req       : c0_req;
    assign w_str  = r_sel ? c1_isstring  : c0_isstring;
    assign w_pat  = r_sel ? c1_ispattern : c0_ispattern;
    assign w_char = r_sel ? c1_chardata  : c0_chardata;

    // On a tie the client that was not granted last wins.
    assign w_pick1     = c1_req & (~c0_req | ~r_last);
    assign w_str_room  = (r_cnt < CNT_W'(STR_MAX));
    assign w_pat_room  = (r_cnt < CNT_W'(PAT_MAX));
    assign w_stale_now = ~r_owner_vld | (r_owner != r_sel);
    assign w_wd_done   = (r_wd == WD_W'(TIMEOUT));

    // A real SME result beats a watchdog expiry landing on the same cycle.
    assign w_res_fire  = (r_state == WAIT_RES) & (sme_valid | w_wd_done);
    assign w_res_match = sme_valid & sme_match;
    assign w_res_idx   = sme_valid ? sme_match_index : 5'd0;
    assign w_res_to    = ~sme_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_sel       <= 1'b0;
            r_last      <= 1'b1;
            r_owner     <= 1'b0;
            r_owner_vld <= 1'b0;
            r_cnt       <= '0;
            r_wd        <= '0;
            r_stale     <= 1'b0;
            r_trunc     <= 1'b0;
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_sme_char  <= 8'd0;
            r_sme_str   <= 1'b0;
            r_sme_pat   <= 1'b0;
            r_vld0      <= 1'b0;
            r_match0    <= 1'b0;
            r_idx0      <= 5'd0;
            r_stale0    <= 1'b0;
            r_trunc0    <= 1'b0;
            r_to0       <= 1'b0;
            r_vld1      <= 1'b0;
            r_match1    <= 1'b0;
            r_idx1      <= 5'd0;
            r_stale1    <= 1'b0;
            r_trunc1    <= 1'b0;
            r_to1       <= 1'b0;
        end else begin
            r_sme_str <= 1'b0;
            r_sme_pat <= 1'b0;

            r_vld0   <= w_res_fire & ~r_sel;
            r_match0 <= w_res_fire & ~r_sel & w_res_match;
            r_idx0   <= (w_res_fire && !r_sel) ? w_res_idx : 5'd0;
            r_stale0 <= w_res_fire & ~r_sel & r_stale;
            r_trunc0 <= w_res_fire & ~r_sel & r_trunc;
            r_to0    <= w_res_fire & ~r_sel & w_res_to;
            r_vld1   <= w_res_fire & r_sel;
            r_match1 <= w_res_fire & r_sel & w_res_match;
            r_idx1   <= (w_res_fire && r_sel) ? w_res_idx : 5'd0;
            r_stale1 <= w_res_fire & r_sel & r_stale;
            r_trunc1 <= w_res_fire & r_sel & r_trunc;
            r_to1    <= w_res_fire & r_sel & w_res_to;

            case (r_state)
                IDLE: begin
                    if (c0_req || c1_req) begin
                        r_sel   <= w_pick1;
                        r_gnt0  <= ~w_pick1;
                        r_gnt1  <= w_pick1;
                        r_state <= GRANTED;
                    end
                end

                GRANTED: begin
                    if (w_str) begin
                        r_owner     <= r_sel;
                        r_owner_vld <= 1'b1;
                        r_sme_char  <= w_char;
                        r_sme_str   <= 1'b1;
                        r_cnt       <= CNT_W'(1);
                        r_state     <= STRING;
                    end else if (w_pat) begin
                        if (w_stale_now)
                            r_stale <= 1'b1;
                        r_sme_char <= w_char;
                        r_sme_pat  <= 1'b1;
                        r_cnt      <= CNT_W'(1);
                        r_state    <= PATTERN;
                    end else if (!w_req) begin
                        r_last  <= r_sel;
                        r_gnt0  <= 1'b0;
                        r_gnt1  <= 1'b0;
                        r_state <= IDLE;
                    end
                end

                STRING: begin
                    if (w_str) begin
                        if (w_str_room) begin
                            r_sme_char <= w_char;
                            r_sme_str  <= 1'b1;
                            r_cnt      <= r_cnt + CNT_W'(1);
                        end else begin
                            r_trunc <= 1'b1;
                        end
                    end else if (w_pat) begin
                        if (w_stale_now)
                            r_stale <= 1'b1;
                        r_sme_char <= w_char;
                        r_sme_pat  <= 1'b1;
                        r_cnt      <= CNT_W'(1);
                        r_state    <= PATTERN;
                    end else begin
                        r_state <= GRANTED;
                    end
                end

                PATTERN: begin
                    if (w_pat) begin
                        if (w_pat_room) begin
                            r_sme_char <= w_char;
                            r_sme_pat  <= 1'b1;
                            r_cnt      <= r_cnt + CNT_W'(1);
                        end else begin
                            r_trunc <= 1'b1;
                        end
                    end else begin
                        r_wd    <= WD_W'(1);
                        r_state <= WAIT_RES;
                    end
                end

                WAIT_RES: begin
                    if (w_res_fire) begin
                        r_stale <= 1'b0;
                        r_trunc <= 1'b0;
                        r_state <= GRANTED;
                    end else begin
                        r_wd <= r_wd + WD_W'(1);
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign c0_gnt         = r_gnt0;
    assign c1_gnt         = r_gnt1;
    assign sme_chardata   = r_sme_char;
    assign sme_isstring   = r_sme_str;
    assign sme_ispattern  = r_sme_pat;
    assign c0_valid       = r_vld0;
    assign c0_match       = r_match0;
    assign c0_match_index = r_idx0;
    assign c0_stale       = r_stale0;
    assign c0_trunc       = r_trunc0;
    assign c0_timeout     = r_to0;
    assign c1_valid       = r_vld1;
    assign c1_match       = r_match1;
    assign c1_match_index = r_idx1;
    assign c1_stale       = r_stale1;
    assign c1_trunc       = r_trunc1;
    assign c1_timeout     = r_to1;

endmodule
